// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared constants for the SPI register slave.
//   Frame layout (24 bits, MSB first):
//     [23]    W flag (1 = write, 0 = read)
//     [22:16] reserved, ignored
//     [15:8]  register address
//     [7:0]   register data
//   FSM state encoding is kept as plain localparam constants so that older
//   blocks sharing this package can compare against them directly.
package spi_reg_pkg;

  localparam int FRAME_BITS = 24;
  localparam int CMD_BITS   = 16;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: brings the asynchronous SPI pins into the clk domain and
// derives single-cycle edge events from them.
//   Parameters: SYNC_STAGES (2..4) flops per pin; CPOL (0 = mode 0, 1 = mode 3).
//   Inputs : clk, rst (sync, active-high), sclk, sen, mosi (asynchronous pins)
//   Outputs: sample_edge - leading sclk edge (CPOL -> !CPOL), one cycle
//            shift_edge  - trailing sclk edge (!CPOL -> CPOL), one cycle
//            sen_s       - synchronized chip enable (active-low)
//            sen_fall    - sen_s went 1 -> 0, one cycle
//            sen_rise    - sen_s went 0 -> 1, one cycle
//            mosi_s      - synchronized mosi, aligned with sample_edge
//            sync_valid  - high once every synchronizer holds real pin samples
//                          (false for SYNC_STAGES cycles after reset)
module spi_edge_sync
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CPOL        = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic sen,
  input  logic mosi,
  output logic sample_edge,
  output logic shift_edge,
  output logic sen_s,
  output logic sen_fall,
  output logic sen_rise,
  output logic mosi_s,
  output logic sync_valid
);

  localparam logic CPOL_BIT = (CPOL != 0);

  logic [SYNC_STAGES-1:0] sclk_sr;
  logic [SYNC_STAGES-1:0] sen_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic [SYNC_STAGES-1:0] fill_sr;
  logic                   sclk_prev;
  logic                   sen_prev;
  logic                   sclk_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sr   <= {SYNC_STAGES{CPOL_BIT}};
      sen_sr    <= '1;
      mosi_sr   <= '0;
      fill_sr   <= '0;
      sclk_prev <= CPOL_BIT;
      sen_prev  <= 1'b1;
    end else begin
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      sen_sr    <= {sen_sr[SYNC_STAGES-2:0], sen};
      mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      // Marches a 1 through at the same rate as the pins, so its MSB marks
      // the first cycle whose synchronized outputs are not reset values.
      fill_sr   <= {fill_sr[SYNC_STAGES-2:0], 1'b1};
      sclk_prev <= sclk_sr[SYNC_STAGES-1];
      sen_prev  <= sen_sr[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sr[SYNC_STAGES-1];
  assign sen_s       = sen_sr[SYNC_STAGES-1];
  assign mosi_s      = mosi_sr[SYNC_STAGES-1];
  assign sync_valid  = fill_sr[SYNC_STAGES-1];

  assign sample_edge = (sclk_s != CPOL_BIT) && (sclk_prev == CPOL_BIT);
  assign shift_edge  = (sclk_s == CPOL_BIT) && (sclk_prev != CPOL_BIT);
  assign sen_fall    = sen_prev & ~sen_s;
  assign sen_rise    = ~sen_prev & sen_s;

endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI (mode 0 / mode 3) slave that turns 24-bit frames into
// register write strobes and, optionally, register readback.
//   Build option: define SPI_REG_SLAVE_READBACK_EN to enable readback
//   (rd_stb/rd_addr/rd_data/miso). Without it read frames are accepted
//   silently, rd_stb/rd_addr/miso are tied to 0 and rd_data is ignored.
//   Parameters: SYNC_STAGES (2..4), CPOL (0 = mode 0, 1 = mode 3).
//   Ports:
//     clk, rst         system clock, synchronous active-high reset
//     sen, sclk, mosi  SPI pins from the master (asynchronous)
//     miso             SPI data to the master
//     wr_stb           one-cycle write strobe, wr_addr/wr_data valid with it
//     rd_stb           one-cycle readback request, rd_addr valid with it
//     rd_data          readback value, sampled one cycle after rd_stb
//     frame_err        one-cycle pulse when a frame ends before 24 bits
//   sclk half-period must be at least SYNC_STAGES+4 clk cycles.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CPOL        = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_stb,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              frame_err
);

  localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(CMD_BITS);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);

  logic                  sample_edge;
  logic                  shift_edge;
  logic                  sen_s;
  logic                  sen_fall;
  logic                  sen_rise;
  logic                  mosi_s;
  logic                  sync_valid;

  logic [1:0]            state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      cnt_inc;
  logic [FRAME_BITS-1:0] frame_sr;
  logic [FRAME_BITS-1:0] frame_nxt;
  logic                  w_bit;
  logic                  wait_high;
  logic                  rd_req;
  logic [ADDR_W-1:0]     rd_req_addr;

  spi_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .CPOL        (CPOL)
  ) u_sync (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .sen         (sen),
    .mosi        (mosi),
    .sample_edge (sample_edge),
    .shift_edge  (shift_edge),
    .sen_s       (sen_s),
    .sen_fall    (sen_fall),
    .sen_rise    (sen_rise),
    .mosi_s      (mosi_s),
    .sync_valid  (sync_valid)
  );

  assign cnt_inc   = bit_cnt + 1'b1;
  assign frame_nxt = {frame_sr[FRAME_BITS-2:0], mosi_s};

  // Frame FSM. sen rising is checked before the sample edge so an abort
  // always wins over a bit arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      frame_sr    <= '0;
      w_bit       <= 1'b0;
      wait_high   <= 1'b1;
      wr_stb      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_req      <= 1'b0;
      rd_req_addr <= '0;
      frame_err   <= 1'b0;
    end else begin
      wr_stb    <= 1'b0;
      rd_req    <= 1'b0;
      frame_err <= 1'b0;

      // A frame that was already running when reset released must not be
      // picked up half way; only a sen that has been seen high re-arms.
      if (wait_high && sync_valid && sen_s) begin
        wait_high <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (sen_fall && !wait_high) begin
            state   <= ST_CMD;
            bit_cnt <= '0;
          end
        end
        ST_CMD, ST_DATA: begin
          if (sen_rise) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else if (sample_edge) begin
            frame_sr <= frame_nxt;
            bit_cnt  <= cnt_inc;
            if (bit_cnt == '0) begin
              w_bit <= mosi_s;
            end
            if (state == ST_CMD && cnt_inc == CNT_CMD) begin
              state       <= ST_DATA;
              rd_req      <= ~w_bit;
              rd_req_addr <= frame_nxt[ADDR_W-1:0];
            end
            if (state == ST_DATA && cnt_inc == CNT_FRAME) begin
              state <= ST_DONE;
              if (w_bit) begin
                wr_stb  <= 1'b1;
                wr_addr <= frame_nxt[DATA_W +: ADDR_W];
                wr_data <= frame_nxt[DATA_W-1:0];
              end
            end
          end
        end
        ST_DONE: begin
          if (sen_rise) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_REG_SLAVE_READBACK_EN
  logic              rd_stb_p1;
  logic [DATA_W-1:0] out_sr;

  // Stage p1: responder data is valid one cycle after the request.
  // The trailing edge right after bit 16 is skipped (bit_cnt must exceed
  // CMD_BITS) so the freshly loaded MSB is still on miso for bit 17.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_stb_p1 <= 1'b0;
      out_sr    <= '0;
    end else begin
      rd_stb_p1 <= rd_req;
      if (state == ST_IDLE) begin
        out_sr <= '0;
      end else if (rd_stb_p1) begin
        out_sr <= rd_data;
      end else if (shift_edge && state == ST_DATA && !w_bit && bit_cnt > CNT_CMD) begin
        out_sr <= {out_sr[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign rd_stb  = rd_req;
  assign rd_addr = rd_req_addr;
  assign miso    = (state == ST_DATA && !w_bit) ? out_sr[DATA_W-1] : 1'b0;
`else
  logic unused_readback;
  assign unused_readback = ^{rd_data, rd_req, rd_req_addr, shift_edge};

  assign rd_stb  = 1'b0;
  assign rd_addr = '0;
  assign miso    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: directed bench for spi_reg_slave. Two instances share
// sen/mosi: dut 0 runs mode 0 (CPOL=0) and dut 1 runs mode 3 (CPOL=1) on an
// inverted copy of sclk, so every frame exercises both polarities.
// Readback expectations follow SPI_REG_SLAVE_READBACK_EN.
module tb_spi_reg_slave;

  localparam int HALF = 8;
`ifdef SPI_REG_SLAVE_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sen = 1'b1;
  logic       mosi = 1'b0;
  logic [1:0] sclk = 2'b10;
  logic [1:0] miso, wr_stb, rd_stb, ferr;
  logic [7:0] wr_addr [2];
  logic [7:0] wr_data [2];
  logic [7:0] rd_addr [2];
  logic [7:0] rd_data [2];

  int total = 0;
  int bad = 0;
  int n_wr [2] = '{0, 0};
  int n_rd [2] = '{0, 0};
  int n_fe [2] = '{0, 0};
  int n_mh [2] = '{0, 0};
  int b_wr [2];
  int b_rd [2];
  int b_fe [2];
  int b_mh [2];
  logic [7:0] cap_wa [2] = '{8'h00, 8'h00};
  logic [7:0] cap_wd [2] = '{8'h00, 8'h00};
  logic [7:0] cap_ra [2] = '{8'h00, 8'h00};
  logic [7:0] mcap [2] = '{8'h00, 8'h00};

  always #5 clk = ~clk;

  spi_reg_slave #(.SYNC_STAGES(2), .CPOL(0)) u_dut0 (
    .clk(clk), .rst(rst), .sen(sen), .sclk(sclk[0]), .mosi(mosi),
    .miso(miso[0]), .wr_stb(wr_stb[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .rd_stb(rd_stb[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .frame_err(ferr[0])
  );

  spi_reg_slave #(.SYNC_STAGES(2), .CPOL(1)) u_dut1 (
    .clk(clk), .rst(rst), .sen(sen), .sclk(sclk[1]), .mosi(mosi),
    .miso(miso[1]), .wr_stb(wr_stb[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .rd_stb(rd_stb[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .frame_err(ferr[1])
  );

  // Register-file responder: 0x5A only in the cycle after rd_stb.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) rd_data[d] <= rd_stb[d] ? 8'h5A : 8'hC3;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wr_stb[d]) begin n_wr[d]++; cap_wa[d] = wr_addr[d]; cap_wd[d] = wr_data[d]; end
      if (rd_stb[d]) begin n_rd[d]++; cap_ra[d] = rd_addr[d]; end
      if (ferr[d]) n_fe[d]++;
      if (miso[d]) n_mh[d]++;
    end
  end

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=0x%0h expected=0x%0h", tag, d, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs(input int d);
    return {4'h0, miso[d], wr_stb[d], rd_stb[d], ferr[d], wr_addr[d], wr_data[d], rd_addr[d]};
  endfunction

  task automatic snap();
    for (int d = 0; d < 2; d++) begin
      b_wr[d] = n_wr[d]; b_rd[d] = n_rd[d]; b_fe[d] = n_fe[d]; b_mh[d] = n_mh[d];
    end
  endtask

  // Leading edge toggles both copies: 0->1 for mode 0, 1->0 for mode 3.
  task automatic spi_bit(input logic b);
    mosi = b;
    repeat (HALF) @(negedge clk);
    for (int d = 0; d < 2; d++) mcap[d] = {mcap[d][6:0], miso[d]};
    sclk = ~sclk;
    repeat (HALF) @(negedge clk);
    sclk = ~sclk;
  endtask

  task automatic send(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) spi_bit(w[i]);
  endtask

  task automatic frame_begin();
    sen = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_end(input int gap);
    repeat (HALF) @(negedge clk);
    sen = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("reset_outs", d, outs(d), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Write 0x80_3C_A5
    snap();
    frame_begin(); send(32'h00803CA5, 24); frame_end(20);
    for (int d = 0; d < 2; d++) begin
      chk("w1_wr_cnt", d, n_wr[d] - b_wr[d], 1);
      chk("w1_addr", d, cap_wa[d], 8'h3C);
      chk("w1_data", d, cap_wd[d], 8'hA5);
      chk("w1_rd_cnt", d, n_rd[d] - b_rd[d], 0);
      chk("w1_miso_hi", d, n_mh[d] - b_mh[d], 0);
      chk("w1_ferr", d, n_fe[d] - b_fe[d], 0);
    end

    // Read 0x00_12_xx
    snap();
    frame_begin(); send(32'h000012C3, 24); frame_end(20);
    for (int d = 0; d < 2; d++) begin
      chk("r1_rd_cnt", d, n_rd[d] - b_rd[d], RB ? 1 : 0);
      chk("r1_rd_addr", d, rd_addr[d], RB ? 8'h12 : 8'h00);
      chk("r1_miso_byte", d, mcap[d], RB ? 8'h5A : 8'h00);
      chk("r1_wr_cnt", d, n_wr[d] - b_wr[d], 0);
      chk("r1_ferr", d, n_fe[d] - b_fe[d], 0);
    end

    // Write 0x80_40_FF aborted after 20 bits, then quick restart
    snap();
    frame_begin(); send(32'h0008040F, 20); frame_end(4);
    for (int d = 0; d < 2; d++) begin
      chk("ab_ferr", d, n_fe[d] - b_fe[d], 1);
      chk("ab_wr_cnt", d, n_wr[d] - b_wr[d], 0);
    end
    snap();
    frame_begin(); send(32'h00804101, 24); frame_end(20);
    for (int d = 0; d < 2; d++) begin
      chk("w2_wr_cnt", d, n_wr[d] - b_wr[d], 1);
      chk("w2_addr", d, cap_wa[d], 8'h41);
      chk("w2_data", d, cap_wd[d], 8'h01);
      chk("w2_ferr", d, n_fe[d] - b_fe[d], 0);
    end

    // 32-bit frame: 8 extra bits after 0x80_07_33
    snap();
    frame_begin(); send(32'h800733A7, 32); frame_end(20);
    for (int d = 0; d < 2; d++) begin
      chk("long_wr_cnt", d, n_wr[d] - b_wr[d], 1);
      chk("long_addr", d, cap_wa[d], 8'h07);
      chk("long_data", d, cap_wd[d], 8'h33);
      chk("long_ferr", d, n_fe[d] - b_fe[d], 0);
    end

    // Reset for 3 cycles at bit 10 of write 0x80_AA_55, master finishes frame
    snap();
    frame_begin(); send(32'h00000202, 10);
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("midrst_outs", d, outs(d), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(32'h00002A55, 14); frame_end(20);
    for (int d = 0; d < 2; d++) begin
      chk("midrst_wr_cnt", d, n_wr[d] - b_wr[d], 0);
      chk("midrst_ferr", d, n_fe[d] - b_fe[d], 0);
    end
    snap();
    frame_begin(); send(32'h00806677, 24); frame_end(20);
    for (int d = 0; d < 2; d++) begin
      chk("w3_wr_cnt", d, n_wr[d] - b_wr[d], 1);
      chk("w3_addr", d, cap_wa[d], 8'h66);
      chk("w3_data", d, cap_wd[d], 8'h77);
    end

    // Read 0x00_12_xx then write 0x80_01_02
    snap();
    frame_begin(); send(32'h00001200, 24); frame_end(20);
    frame_begin(); send(32'h00800102, 24); frame_end(20);
    for (int d = 0; d < 2; d++) begin
      chk("rw_rd_cnt", d, n_rd[d] - b_rd[d], RB ? 1 : 0);
      chk("rw_miso_byte", d, mcap[d], 8'h00);
      chk("rw_wr_cnt", d, n_wr[d] - b_wr[d], 1);
      chk("rw_addr", d, cap_wa[d], 8'h01);
      chk("rw_data", d, cap_wd[d], 8'h02);
      chk("rw_ferr", d, n_fe[d] - b_fe[d], 0);
    end
    chk("rw_miso_hi_nrb", 1, n_mh[1] - b_mh[1] - (RB ? n_mh[1] - b_mh[1] : 0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
